mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 162 ++++++++++++++++
 tb/tb_mc_control.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle MIPS-style main control FSM (Moore, FETCH strobes gated by mem_ready).
// Define MC_CONTROL_ANDI_EN to decode andi (opcode 001100) through the ANDIEX state.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
`ifdef MC_CONTROL_ANDI_EN
    S_ITWB   = 4'd11,
    S_ANDIEX = 4'd12
`else
    S_ITWB   = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_CONTROL_ANDI_EN
  localparam logic [5:0] OP_ANDI = 6'b001100;
`endif

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  assign state = r_state;

  // Unused encodings fall to the default arm: all strobes low, back to FETCH.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    w_next      = S_FETCH;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYP:      w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
`ifdef MC_CONTROL_ANDI_EN
          OP_ANDI:      w_next = S_ANDIEX;
`endif
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ITWB;
      end
`ifdef MC_CONTROL_ANDI_EN
      S_ANDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        w_next  = S_ITWB;
      end
`endif
      S_ITWB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboarded random-instruction bench for mc_control.
// Expected per-cycle outputs come from per-opcode state walks and a state output table.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, asb, aop;
    logic       ill;
    logic [3:0] st;
  } out_t;

  out_t q[$];
  out_t m_e, m_a;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic out_t actual();
    out_t a;
    a = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
          IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
          ALUOp, illegal_op, state};
    return a;
  endfunction

  function automatic bit legal(logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000,
      6'b000100, 6'b000010, 6'b001000: return 1'b1;
`ifdef MC_CONTROL_ANDI_EN
      6'b001100: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Output table indexed by the architectural state number.
  function automatic out_t exp_vec(int st, bit mr, logic [5:0] op);
    out_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0: begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      1: begin e.asb = 2'b11; e.ill = !legal(op); end
      2: begin e.asa = 1; e.asb = 2'b10; end
      3: begin e.mrd = 1; e.iord = 1; end
      4: begin e.m2r = 1; e.rw = 1; end
      5: begin e.mwr = 1; e.iord = 1; end
      6: begin e.asa = 1; e.aop = 2'b10; end
      7: begin e.rd = 1; e.rw = 1; end
      8: begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; end
      9: begin e.pcw = 1; e.pcs = 2'b10; end
      10: begin e.asa = 1; e.asb = 2'b10; end
      11: begin e.rw = 1; end
      12: begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b11; end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      m_a = actual();
      checks++;
      if (m_a !== m_e) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t act=%h exp=%h exp_state=%0d",
                 $time, m_a, m_e, m_e.st);
      end
    end
  end

  task automatic step(int st, bit mr);
    mem_ready = mr;
    q.push_back(exp_vec(st, mr, opcode));
    @(posedge clk);
    #1;
  endtask

  task automatic direct(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_instr(logic [5:0] op, int fw, int mw, bit abort);
    int seq[$];
    opcode = op;
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 9};
      6'b001000: seq = '{0, 1, 10, 11};
`ifdef MC_CONTROL_ANDI_EN
      6'b001100: seq = '{0, 1, 12, 11};
`endif
      default:   seq = '{0, 1};
    endcase
    foreach (seq[i]) begin
      if (seq[i] == 0) begin
        repeat (fw) step(0, 1'b0);
        step(0, 1'b1);
      end else if (seq[i] == 3 || seq[i] == 5) begin
        repeat (mw) step(seq[i], 1'b0);
        if (abort && seq[i] == 5) begin
          mem_ready = 1'b0;
          #1 reset = 1'b1;
          #1;
          direct("rst_in_memwr_state", 32'(state), 32'd0);
          direct("rst_in_memwr_memwrite", 32'(MemWrite), 32'd0);
          direct("rst_fetch_memread", 32'(MemRead), 32'd1);
          @(posedge clk);
          @(posedge clk);
          #1;
          direct("rst_held_state", 32'(state), 32'd0);
          reset = 1'b0;
          return;
        end
        step(seq[i], 1'b1);
      end else begin
        step(seq[i], 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[8];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b000010, 6'b001000, 6'b001100, 6'b111111};
    #2;
    direct("reset_state", 32'(state), 32'd0);
    direct("reset_alusrcb", 32'(ALUSrcB), 32'd1);
    direct("reset_irwrite_low", 32'(IRWrite), 32'd0);
    direct("reset_illegal", 32'(illegal_op), 32'd0);
    mem_ready = 1'b1;
    #1;
    direct("reset_irwrite_comb", 32'(IRWrite), 32'd1);
    @(posedge clk);
    #1;
    direct("reset_hold_state", 32'(state), 32'd0);
    reset = 1'b0;

    run_instr(6'b100011, 0, 0, 1'b0);
    run_instr(6'b000000, 3, 0, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b0);
    run_instr(6'b001100, 0, 0, 1'b0);
    run_instr(6'b000010, 1, 0, 1'b0);
    run_instr(6'b101011, 0, 2, 1'b0);
    run_instr(6'b100011, 2, 3, 1'b0);
    run_instr(6'b101011, 0, 2, 1'b1);
    run_instr(6'b001000, 0, 0, 1'b0);
    run_instr(6'b000001, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int k;
      k = $urandom_range(0, 8);
      op = (k == 8) ? 6'($urandom_range(0, 63)) : ops[k];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    #1;
    direct("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
